// File: rtl/dcache_wt_128.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Loads hit combinationally; read misses fill a 128-bit line, stores always go to memory.
module dcache_wt_128 #(
  parameter int DATA_WIDTH = 32,
  parameter int LINES      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             cpu_address,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  input  logic                    cpu_read,
  input  logic                    cpu_write,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  output logic                    stall,
  output logic [31:0]             mem_address,
  output logic                    mem_valid,
  output logic                    mem_write,
  output logic [4*DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]              mem_wmask,
  input  logic [4*DATA_WIDTH-1:0] mem_rdata,
  input  logic                    mem_ready
);

  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = 28 - IDX_W;
  localparam int LINE_W = 4 * DATA_WIDTH;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] ACK   = 2'd3;

  function automatic logic [DATA_WIDTH-1:0] f_select_word(input logic [LINE_W-1:0] line,
                                                           input logic [1:0] off);
    logic [DATA_WIDTH-1:0] word;
    case (off)
      2'd0:    word = line[DATA_WIDTH-1:0];
      2'd1:    word = line[2*DATA_WIDTH-1:DATA_WIDTH];
      2'd2:    word = line[3*DATA_WIDTH-1:2*DATA_WIDTH];
      2'd3:    word = line[4*DATA_WIDTH-1:3*DATA_WIDTH];
      default: word = {DATA_WIDTH{1'b0}};
    endcase
    return word;
  endfunction

  function automatic logic [LINE_W-1:0] f_merge_word(input logic [LINE_W-1:0] line,
                                                      input logic [DATA_WIDTH-1:0] word,
                                                      input logic [1:0] off);
    logic [LINE_W-1:0] merged;
    merged = line;
    case (off)
      2'd0:    merged[DATA_WIDTH-1:0]              = word;
      2'd1:    merged[2*DATA_WIDTH-1:DATA_WIDTH]   = word;
      2'd2:    merged[3*DATA_WIDTH-1:2*DATA_WIDTH] = word;
      2'd3:    merged[4*DATA_WIDTH-1:3*DATA_WIDTH] = word;
      default: merged = line;
    endcase
    return merged;
  endfunction

  function automatic logic [3:0] f_lane_mask(input logic [1:0] off);
    logic [3:0] mask;
    case (off)
      2'd0:    mask = 4'b0001;
      2'd1:    mask = 4'b0010;
      2'd2:    mask = 4'b0100;
      2'd3:    mask = 4'b1000;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [LINES-1:0]      r_valid;
  logic [TAG_W-1:0]      r_tag  [LINES];
  logic [LINE_W-1:0]     r_data [LINES];
  logic [27:0]           r_line;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [1:0]            r_offset;

  logic [IDX_W-1:0]      w_index;
  logic [TAG_W-1:0]      w_tag;
  logic [1:0]            w_offset;
  logic                  w_hit;
  logic [IDX_W-1:0]      w_fill_index;
  logic [TAG_W-1:0]      w_fill_tag;
  logic                  w_fill_done;
  logic                  w_store_hit;
  logic                  w_idle_store;
  logic                  w_idle_miss;
  logic                  w_unused_addr;

  assign w_index       = cpu_address[3+IDX_W:4];
  assign w_tag         = cpu_address[31:4+IDX_W];
  assign w_offset      = cpu_address[3:2];
  assign w_unused_addr = ^cpu_address[1:0];
  assign w_hit         = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_fill_index  = r_line[IDX_W-1:0];
  assign w_fill_tag    = r_line[27:IDX_W];
  assign w_fill_done   = (r_state == FILL) && mem_ready;
  assign w_idle_store  = (r_state == IDLE) && cpu_write;
  assign w_idle_miss   = (r_state == IDLE) && !cpu_write && cpu_read && !w_hit;
  assign w_store_hit   = w_idle_store && w_hit;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (cpu_write) begin
          w_next_state = WRITE;
        end else if (cpu_read && !w_hit) begin
          w_next_state = FILL;
        end else begin
          w_next_state = IDLE;
        end
      end
      FILL: begin
        if (mem_ready) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = FILL;
        end
      end
      WRITE: begin
        if (mem_ready) begin
          w_next_state = ACK;
        end else begin
          w_next_state = WRITE;
        end
      end
      ACK:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= {LINES{1'b0}};
    end else if (w_fill_done) begin
      r_valid[w_fill_index] <= 1'b1;
    end
  end

  // Request latches keep the memory-side outputs stable while the CPU side is frozen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_line   <= 28'd0;
      r_wdata  <= {DATA_WIDTH{1'b0}};
      r_offset <= 2'd0;
    end else if (w_idle_store) begin
      r_line   <= cpu_address[31:4];
      r_wdata  <= cpu_wdata;
      r_offset <= w_offset;
    end else if (w_idle_miss) begin
      r_line   <= cpu_address[31:4];
    end
  end

  // Tag/data arrays are qualified by r_valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_data[w_fill_index] <= mem_rdata;
      r_tag[w_fill_index]  <= w_fill_tag;
    end else if (w_store_hit) begin
      r_data[w_index] <= f_merge_word(r_data[w_index], cpu_wdata, w_offset);
    end
  end

  always_comb begin
    stall     = 1'b0;
    cpu_rdata = {DATA_WIDTH{1'b0}};
    case (r_state)
      IDLE: begin
        if (cpu_write) begin
          stall = 1'b1;
        end else if (cpu_read && w_hit) begin
          cpu_rdata = f_select_word(r_data[w_index], w_offset);
        end else if (cpu_read) begin
          stall = 1'b1;
        end else begin
          stall = 1'b0;
        end
      end
      FILL:    stall = 1'b1;
      WRITE:   stall = 1'b1;
      ACK:     stall = 1'b0;
      default: stall = 1'b0;
    endcase
  end

  // Memory side decodes only registered state so it cannot glitch with cpu_address.
  always_comb begin
    mem_valid   = 1'b0;
    mem_write   = 1'b0;
    mem_address = 32'd0;
    mem_wdata   = {LINE_W{1'b0}};
    mem_wmask   = 4'b0000;
    case (r_state)
      FILL: begin
        mem_valid   = 1'b1;
        mem_address = {r_line, 4'b0000};
      end
      WRITE: begin
        mem_valid   = 1'b1;
        mem_write   = 1'b1;
        mem_address = {r_line, 4'b0000};
        mem_wdata   = {4{r_wdata}};
        mem_wmask   = f_lane_mask(r_offset);
      end
      default: begin
        mem_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_wt_128.sv
// Directed, table-driven bench for dcache_wt_128 with a latency-programmable line memory model.
module tb_dcache_wt_128;

  logic         clk;
  logic         reset;
  logic [31:0]  cpu_address;
  logic [31:0]  cpu_wdata;
  logic         cpu_read;
  logic         cpu_write;
  logic [31:0]  cpu_rdata;
  logic         stall;
  logic [31:0]  mem_address;
  logic         mem_valid;
  logic         mem_write;
  logic [127:0] mem_wdata;
  logic [3:0]   mem_wmask;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  dcache_wt_128 #(.DATA_WIDTH(32), .LINES(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_rdata(cpu_rdata), .stall(stall),
    .mem_address(mem_address), .mem_valid(mem_valid), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_stalls;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_wmask;
  } vec_t;

  vec_t         vecs [16];
  logic [127:0] mem_lines [256];
  int           lat;
  bit           rdy_always;
  int           cnt;
  int           valid_cycles;
  logic [31:0]  last_raddr;
  logic [31:0]  last_waddr;
  logic [127:0] last_wdata;
  logic [3:0]   last_wmask;
  int           n_checks;
  int           n_fail;

  task automatic check(input string name, input int idx, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (v%0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  // Memory model: ready in the lat-th cycle of mem_valid, or always when rdy_always.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 128'd0;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_valid) begin
        cnt++;
        valid_cycles++;
        mem_ready = rdy_always || (cnt >= lat);
        mem_rdata = mem_lines[mem_address[11:4]];
        if (mem_write) begin
          last_waddr = mem_address;
          last_wdata = mem_wdata;
          last_wmask = mem_wmask;
          if (mem_ready) begin
            for (int n = 0; n < 4; n++) begin
              if (mem_wmask[n]) mem_lines[mem_address[11:4]][32*n +: 32] = mem_wdata[32*n +: 32];
            end
          end
        end else begin
          last_raddr = mem_address;
        end
      end else begin
        cnt = 0;
        mem_ready = rdy_always;
      end
    end
  end

  task automatic do_access(input vec_t v, input int idx);
    int          stalls;
    int          bad_rdata;
    bit          done;
    logic [31:0] got;
    cpu_read    = v.rd;
    cpu_write   = v.wr;
    cpu_address = v.addr;
    cpu_wdata   = v.wdata;
    last_raddr  = 32'hFFFF_FFFF;
    last_waddr  = 32'hFFFF_FFFF;
    last_wdata  = 128'd0;
    last_wmask  = 4'h0;
    stalls      = 0;
    bad_rdata   = 0;
    done        = 1'b0;
    got         = 32'hFFFF_FFFF;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (stall) begin
        stalls++;
        if (cpu_rdata !== 32'd0) bad_rdata++;
      end else begin
        got  = cpu_rdata;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    check("timeout", idx, {127'd0, done}, 128'd1);
    check("stall_cycles", idx, 128'(stalls), 128'(v.exp_stalls));
    check("cpu_rdata", idx, {96'd0, got}, {96'd0, v.exp_rdata});
    check("rdata_zero_when_stalled", idx, 128'(bad_rdata), 128'd0);
    if (v.wr) begin
      check("mem_wmask", idx, {124'd0, last_wmask}, {124'd0, v.exp_wmask});
      check("mem_wdata", idx, last_wdata, {4{v.wdata}});
      check("mem_waddr", idx, {96'd0, last_waddr}, {96'd0, v.addr[31:4], 4'h0});
    end else if (v.rd && v.exp_stalls > 0) begin
      check("fill_addr", idx, {96'd0, last_raddr}, {96'd0, v.addr[31:4], 4'h0});
    end else begin
      check("no_fill", idx, {96'd0, last_raddr}, 128'h0FFFF_FFFF);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    lat          = 3;
    rdy_always   = 1'b0;
    valid_cycles = 0;
    reset        = 1'b1;
    cpu_address  = 32'd0;
    cpu_wdata    = 32'd0;
    cpu_read     = 1'b0;
    cpu_write    = 1'b0;
    for (int i = 0; i < 256; i++) begin
      for (int w = 0; w < 4; w++) begin
        logic [31:0] val;
        val = 32'h1000_0000 + 32'(i * 16 + w * 4);
        mem_lines[i][32*w +: 32] = val;
      end
    end
    mem_lines[4] = {32'h0000_000D, 32'h0000_000C, 32'h0000_000B, 32'h0000_000A};

    vecs[0]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,           0, 32'h0,           4'b0000};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,           4, 32'h0000_000A,   4'b0000};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0048, 32'h0,           0, 32'h0000_000C,   4'b0000};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF,   4, 32'h0,           4'b0010};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0048, 32'h0BAD_F00D,   4, 32'h0,           4'b0100};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,           0, 32'hDEAD_BEEF,   4'b0000};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0048, 32'h0,           0, 32'h0BAD_F00D,   4'b0000};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0080, 32'h1234_56EF,   4, 32'h0,           4'b0001};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,           4, 32'h1234_56EF,   4'b0000};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0084, 32'h0,           0, 32'h1000_0084,   4'b0000};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,           4, 32'h1000_0000,   4'b0000};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,           4, 32'h1234_56EF,   4'b0000};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,           4, 32'h1000_0000,   4'b0000};
    vecs[13] = '{1'b1, 1'b1, 32'h0000_004C, 32'h55AA_55AA,   4, 32'h0,           4'b1000};
    vecs[14] = '{1'b1, 1'b0, 32'h0000_004C, 32'h0,           0, 32'h55AA_55AA,   4'b0000};
    vecs[15] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,           0, 32'h0000_000A,   4'b0000};

    #1;
    check("reset_stall", 0, {127'd0, stall}, 128'd0);
    check("reset_mem_valid", 0, {127'd0, mem_valid}, 128'd0);
    check("reset_mem_write", 0, {127'd0, mem_write}, 128'd0);
    check("reset_mem_wmask", 0, {124'd0, mem_wmask}, 128'd0);
    check("reset_mem_address", 0, {96'd0, mem_address}, 128'd0);
    check("reset_mem_wdata", 0, mem_wdata, 128'd0);
    check("reset_cpu_rdata", 0, {96'd0, cpu_rdata}, 128'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      do_access(vecs[i], i);
    end

    // Reset in the second FILL cycle: request abandoned, all lines invalidated.
    cpu_read    = 1'b1;
    cpu_address = 32'h0000_0100;
    @(posedge clk);
    #1;
    check("fill_started", 100, {127'd0, mem_valid}, 128'd1);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    cpu_read = 1'b0;
    #1;
    check("reset_drops_mem_valid", 100, {127'd0, mem_valid}, 128'd0);
    check("reset_mem_address_cleared", 100, {96'd0, mem_address}, 128'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    do_access('{1'b1, 1'b0, 32'h0000_0100, 32'h0, 4, 32'h1000_0100, 4'b0000}, 101);
    do_access('{1'b1, 1'b0, 32'h0000_0040, 32'h0, 4, 32'h0000_000A, 4'b0000}, 102);

    // mem_ready held high while idle must not start anything; then a 1-cycle fill.
    rdy_always   = 1'b1;
    valid_cycles = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("idle_ready_stall", 200, {127'd0, stall}, 128'd0);
    check("idle_ready_mem_valid", 200, {127'd0, mem_valid}, 128'd0);
    check("idle_ready_no_fills", 200, 128'(valid_cycles), 128'd0);
    @(posedge clk);
    #1;
    do_access('{1'b1, 1'b0, 32'h0000_0200, 32'h0, 2, 32'h1000_0200, 4'b0000}, 201);
    rdy_always = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_wt_128.md
# dcache_wt_128

Direct-mapped, write-through, no-write-allocate data cache for the MEM stage of the five-stage pipeline. It sits between the EX/MEM register (ALU result as address, forwarded rt as store data, mem_read/mem_write controls) and a 128-bit-line data memory with the same valid/ready handshake as the instruction-side memory. It stalls the pipeline on read misses and on every store, and returns load data combinationally on hits.

## Interface
Parameters:
- DATA_WIDTH, 32, CPU word width; fixed at 32.
- LINES, 8, number of cache lines; power of two, 2..64.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all valid bits and the FSM.
- cpu_address  in  32  byte address from EX/MEM. Bits [1:0] are ignored, [3:2] are the word offset, [3+log2(LINES):4] are the index, and the remaining upper bits are the tag.
- cpu_wdata  in  32  store data.
- cpu_read  in  1  load request.
- cpu_write  in  1  store request; wins if asserted together with cpu_read.
- cpu_rdata  out  32  load data; valid when cpu_read=1 and stall=0.
- stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM, and zeroes the MEM/WB input.
- mem_address  out  32  line-aligned address (bits [3:0]=0).
- mem_valid  out  1  memory request strobe.
- mem_write  out  1  1 = write, 0 = line read.
- mem_wdata  out  128  store word replicated into all four lanes.
- mem_wmask  out  4  one-hot word-lane enable for writes. Lane n is bits [32n+31:32n].
- mem_rdata  in  128  fill data; sampled when mem_ready=1.
- mem_ready  in  1  completion for the current request.

## Operation
- Storage: per line, a valid bit, a tag, and 128 bits of data. All valid bits are 0 after reset.
- hit = valid[index] && tag[index]==addr_tag. Computed combinationally from cpu_address.
- States:
  - IDLE
  - FILL (read miss in progress)
  - WRITE (store in progress)
  - ACK (one-cycle store completion)
- IDLE:
  - No request: stall=0.
  - cpu_read and hit: cpu_rdata = the selected word, stall=0, state stays IDLE.
  - cpu_read and miss: stall=1. Latch the line address, go to FILL.
  - cpu_write: stall=1. Latch address, data and offset, go to WRITE. If hit, the cached word is updated at this edge. If miss, the cache is untouched (no allocate).
- FILL:
  - stall=1, mem_valid=1, mem_write=0, mem_address = latched line address.
  - On an edge with mem_ready=1: write mem_rdata into the line, set its tag and valid bit, go to IDLE.
  - The request is then re-evaluated in IDLE, hits, and stall drops.
- WRITE:
  - stall=1, mem_valid=1, mem_write=1, mem_wmask = 1<<offset, mem_wdata = {4{wdata}}.
  - On an edge with mem_ready=1: go to ACK.
- ACK:
  - stall=0 and cpu inputs are ignored, so the still-present store is not reissued.
  - Next state IDLE.
- mem_valid, mem_write, mem_address, mem_wmask and mem_wdata are decoded only from registered state and latches, so they are glitch-free and stable while mem_valid=1.
- cpu_rdata is 0 whenever cpu_read=0 or stall=1.
- mem_ready outside FILL/WRITE is ignored.

## Timing
- Reset values:
  - state IDLE
  - all valid bits 0
  - stall 0 (with no request)
  - mem_valid 0, mem_write 0, mem_wmask 0
  - mem_address 0, mem_wdata 0
  - cpu_rdata 0
- Load hit: 0 stall cycles.
- Load miss with memory latency L:
  - The request is presented in cycle 0 (IDLE, stall=1).
  - mem_valid is high in cycles 1..L (ready in cycle L).
  - The hit is in cycle L+1.
  - Total stall cycles = L+1.
- Store with latency L: stall cycles = L+1 (cycle 0 IDLE, cycles 1..L WRITE), then ACK with stall=0.
- Back-to-back stores: the second store enters IDLE one cycle after ACK.
- Reset asserted mid-FILL or mid-WRITE:
  - mem_valid drops immediately (asynchronously).
  - No line is updated.
  - The partial store is lost.
- A store hit updates the cache before memory completes. A load to the same word issued after ACK must return the new value.
- cpu_read and cpu_write together: treated as a store; cpu_rdata=0.

## Test plan
- Cold load from 0x40 with L=3 and line 0x40 = {0xD,0xC,0xB,0xA} (word0 = 0xA): stall is high for 4 cycles, mem_address=0x40, then cpu_rdata=0xA. A following load of 0x48 returns 0xC with 0 stall cycles.
- Store 0xDEADBEEF to 0x44 (line resident): mem_wmask=4'b0010 and mem_wdata lane 1 = 0xDEADBEEF. Stall lasts L+1 cycles, then one ACK cycle. A load of 0x44 then hits and returns 0xDEADBEEF.
- Store to 0x80 (not resident), then load 0x80: the store must not allocate. The load misses, fills from memory, and returns 0x...EF written by the store.
- Conflict: with LINES=8, load 0x00 and then load 0x80 (same index 0): the second load misses and evicts the first. Reloading 0x00 misses again.
- Assert reset for 1 cycle during FILL (cycle 2 of L=3): mem_valid is 0 during reset, and a later load to the same address misses again.
- Hold mem_ready=1 permanently while idle: no state change and no spurious fills. Then a load miss completes in 2 stall cycles (L=1).
